// File: rtl/fp_mul_pkg.sv
// Shared types and constants for the single-precision multiplier
// round/pack stage and sibling FPU ops.
package fp_mul_pkg;

   localparam int EW = 12;

   typedef enum logic [1:0] {
      CLS_NORM = 2'd0,
      CLS_ZERO = 2'd1,
      CLS_INF  = 2'd2,
      CLS_NAN  = 2'd3
   } cls_e;

   typedef enum logic [2:0] {
      RNE = 3'd0,
      RTZ = 3'd1,
      RDN = 3'd2,
      RUP = 3'd3,
      RMM = 3'd4
   } rmode_e;

   localparam logic [31:0] QNAN    = 32'h7FC00000;
   localparam logic [30:0] MAX_FIN = 31'h7F7FFFFF;
   localparam logic signed [EW-1:0] EXP_MAX = 12'sd255;

   typedef struct packed {
      logic                   sign;
      cls_e                   cls;
      rmode_e                 rm;
      logic signed [EW-1:0]   exp_n;
      logic [22:0]            mant;
      logic                   guard;
      logic                   sticky;
   } s1_t;

   // Reserved encodings fall back to round-to-nearest-even.
   function automatic rmode_e to_rmode(input logic [2:0] m);
      case (m)
         3'd1:    return RTZ;
         3'd2:    return RDN;
         3'd3:    return RUP;
         3'd4:    return RMM;
         default: return RNE;
      endcase
   endfunction

endpackage

// File: rtl/fp_mul_round_if.sv
// Upstream product / downstream result handshake bundle
// for the multiplier round stage.
interface fp_mul_round_if #(
   parameter int EXP_W = 10,
   parameter int FRC_W = 48
);
   logic             in_valid;
   logic             in_ready;
   logic             in_sign;
   logic [EXP_W-1:0] in_exp;
   logic [FRC_W-1:0] in_frc;
   logic [1:0]       in_cls;
   logic [2:0]       r_mode;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      fp_Z;
   logic             ovrf;
   logic             udrf;

   modport master (
      output in_valid, in_sign, in_exp, in_frc, in_cls, r_mode,
      output out_ready,
      input  in_ready, out_valid, fp_Z, ovrf, udrf
   );

   modport slave (
      input  in_valid, in_sign, in_exp, in_frc, in_cls, r_mode,
      input  out_ready,
      output in_ready, out_valid, fp_Z, ovrf, udrf
   );
endinterface

// File: rtl/fp_round_inc.sv
// Round-increment decision from sign, guard, sticky and lsb
// under the selected IEEE rounding mode.
module fp_round_inc
   import fp_mul_pkg::*;
(
   input  logic   i_sign,
   input  logic   i_guard,
   input  logic   i_sticky,
   input  logic   i_lsb,
   input  rmode_e i_rm,
   output logic   o_inc
);

   logic w_inexact;

   assign w_inexact = i_guard | i_sticky;

   always_comb begin
      o_inc = 1'b0;
      case (i_rm)
         RTZ:     o_inc = 1'b0;
         RDN:     o_inc = i_sign & w_inexact;
         RUP:     o_inc = ~i_sign & w_inexact;
         RMM:     o_inc = i_guard;
         default: o_inc = i_guard & (i_sticky | i_lsb);
      endcase
   end

endmodule

// File: rtl/fp_mul_round.sv
// Two-stage normalize / round-and-pack back end of the
// single-precision multiplier; subnormal results flush to zero.
module fp_mul_round
   import fp_mul_pkg::*;
#(
   parameter int EXP_W = 10,
   parameter int FRC_W = 48
) (
   input logic           clk,
   input logic           rst_n,
   fp_mul_round_if.slave bus
);

   logic                    r_s1v;
   s1_t                     r_s1;
   logic                    r_ov;
   logic [31:0]             r_z;
   logic                    r_ovf;
   logic                    r_udf;

   logic                    w_s2_free;
   logic                    w_in_ready;
   logic [FRC_W-1:0]        w_frc;
   logic signed [EXP_W-1:0] w_ein;
   logic signed [EW-1:0]    w_ein_x;
   s1_t                     w_s1;

   logic                    w_inc;
   logic [23:0]             w_sum;
   logic signed [EW-1:0]    w_expf;
   logic [31:0]             w_z;
   logic                    w_ovf;
   logic                    w_udf;

   assign w_s2_free  = ~r_ov | bus.out_ready;
   assign w_in_ready = ~r_s1v | w_s2_free;
   assign w_frc      = bus.in_frc;
   assign w_ein      = bus.in_exp;
   assign w_ein_x    = EW'(w_ein);

   // Stage 1: a carry into bit 47 shifts the binary point left by one.
   always_comb begin
      w_s1.sign = bus.in_sign;
      w_s1.cls  = cls_e'(bus.in_cls);
      w_s1.rm   = to_rmode(bus.r_mode);
      if (w_frc[FRC_W-1]) begin
         w_s1.mant   = w_frc[FRC_W-2 -: 23];
         w_s1.guard  = w_frc[FRC_W-25];
         w_s1.sticky = |w_frc[FRC_W-26:0];
         w_s1.exp_n  = w_ein_x + EW'(1);
      end else begin
         w_s1.mant   = w_frc[FRC_W-3 -: 23];
         w_s1.guard  = w_frc[FRC_W-26];
         w_s1.sticky = |w_frc[FRC_W-27:0];
         w_s1.exp_n  = w_ein_x;
      end
   end

   fp_round_inc u_inc (
      .i_sign   (r_s1.sign),
      .i_guard  (r_s1.guard),
      .i_sticky (r_s1.sticky),
      .i_lsb    (r_s1.mant[0]),
      .i_rm     (r_s1.rm),
      .o_inc    (w_inc)
   );

   // Mantissa carry-out leaves zeros in [22:0] and bumps the exponent.
   assign w_sum  = {1'b0, r_s1.mant} + 24'(w_inc);
   assign w_expf = r_s1.exp_n + EW'(w_sum[23]);

   always_comb begin
      w_z   = '0;
      w_ovf = 1'b0;
      w_udf = 1'b0;
      if (r_s1.cls == CLS_NAN) begin
         w_z = QNAN;
      end else if (r_s1.cls == CLS_INF) begin
         w_z = {r_s1.sign, 8'hFF, 23'd0};
      end else if (r_s1.cls == CLS_ZERO) begin
         w_z = {r_s1.sign, 31'd0};
      end else if (r_s1.exp_n <= 0) begin
         w_z   = {r_s1.sign, 31'd0};
         w_udf = 1'b1;
      end else if (w_expf >= EXP_MAX) begin
         w_ovf = 1'b1;
         case (r_s1.rm)
            RTZ: w_z = {r_s1.sign, MAX_FIN};
            RDN: w_z = r_s1.sign ? 32'hFF800000
                                 : {1'b0, MAX_FIN};
            RUP: w_z = r_s1.sign ? {1'b1, MAX_FIN}
                                 : 32'h7F800000;
            default: w_z = {r_s1.sign, 8'hFF, 23'd0};
         endcase
      end else begin
         w_z = {r_s1.sign, w_expf[7:0], w_sum[22:0]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1v <= 1'b0;
         r_s1  <= '0;
         r_ov  <= 1'b0;
         r_z   <= '0;
         r_ovf <= 1'b0;
         r_udf <= 1'b0;
      end else begin
         if (w_in_ready) begin
            r_s1v <= bus.in_valid;
            if (bus.in_valid) r_s1 <= w_s1;
         end
         if (w_s2_free) begin
            r_ov <= r_s1v;
            if (r_s1v) begin
               r_z   <= w_z;
               r_ovf <= w_ovf;
               r_udf <= w_udf;
            end
         end
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_ov;
   assign bus.fp_Z      = r_z;
   assign bus.ovrf      = r_ovf;
   assign bus.udrf      = r_udf;

endmodule

// File: tb/tb_fp_mul_round.sv
// Scoreboard bench for fp_mul_round: directed vectors queued at
// acceptance, checked by an independent output monitor.
module tb_fp_mul_round;

   typedef struct packed {
      logic [31:0] z;
      logic        ov;
      logic        ud;
   } exp_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   int   n_acc;
   bit   bp_done;
   exp_t sb[$];

   fp_mul_round_if #(.EXP_W(10), .FRC_W(48)) bus ();

   fp_mul_round #(.EXP_W(10), .FRC_W(48)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n && bus.out_valid) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out got %h ov=%b ud=%b",
                     bus.fp_Z, bus.ovrf, bus.udrf);
         end else begin
            if ({bus.fp_Z, bus.ovrf, bus.udrf} !== sb[0]) begin
               errors++;
               $display("FAIL result got %h/%b/%b want %h/%b/%b",
                        bus.fp_Z, bus.ovrf, bus.udrf,
                        sb[0].z, sb[0].ov, sb[0].ud);
            end
            if (bus.out_ready) void'(sb.pop_front());
         end
         checks++;
         if (bus.ovrf && bus.udrf) begin
            errors++;
            $display("FAIL flags_both got ov=1 ud=1 want not both");
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, got, want);
      end
   endtask

   task automatic send(input logic s, input logic [9:0] e,
                       input logic [47:0] f, input logic [1:0] c,
                       input logic [2:0] rm, input logic [31:0] z,
                       input logic ov, input logic ud);
      bit done;
      done = 0;
      bus.in_sign  = s;
      bus.in_exp   = e;
      bus.in_frc   = f;
      bus.in_cls   = c;
      bus.r_mode   = rm;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 64 && !done; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            sb.push_back('{z: z, ov: ov, ud: ud});
            n_acc++;
            done = 1;
         end
         @(posedge clk);
         #1;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL send_timeout got no in_ready want accept");
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && sb.size() != 0; i++) begin
         @(posedge clk);
         #1;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout got %0d pending want 0",
                  sb.size());
      end
   endtask

   localparam logic [47:0] ONE    = 48'd1 << 46;
   localparam logic [47:0] ONE5SQ = 48'd9 << 44;
   localparam logic [47:0] ALL1   = 48'hFFFFFF << 22;
   localparam logic [47:0] TWO    = 48'd1 << 47;
   localparam logic [47:0] ONE_ST = (48'd1 << 46) | 48'd1;
   localparam logic [47:0] ONE_HF = (48'd1 << 46) | (48'd1 << 22);

   initial begin
      checks       = 0;
      errors       = 0;
      n_acc        = 0;
      bp_done      = 0;
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_sign  = 1'b0;
      bus.in_exp   = '0;
      bus.in_frc   = '0;
      bus.in_cls   = '0;
      bus.r_mode   = '0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_fp_Z", bus.fp_Z, 32'd0);
      chk("rst_flags", {30'd0, bus.ovrf, bus.udrf}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

      send(0, 10'd127, ONE,    0, 3'd0, 32'h3F800000, 0, 0);
      send(0, 10'd127, ONE5SQ, 0, 3'd0, 32'h40100000, 0, 0);
      send(0, 10'd127, ALL1,   0, 3'd0, 32'h40000000, 0, 0);
      send(0, 10'd127, ALL1,   0, 3'd1, 32'h3FFFFFFF, 0, 0);
      send(0, 10'd254, TWO,    0, 3'd0, 32'h7F800000, 1, 0);
      send(0, 10'd254, TWO,    0, 3'd1, 32'h7F7FFFFF, 1, 0);
      send(1, 10'd254, TWO,    0, 3'd2, 32'hFF800000, 1, 0);
      send(1, 10'd254, TWO,    0, 3'd3, 32'hFF7FFFFF, 1, 0);
      send(0, 10'd254, TWO,    0, 3'd4, 32'h7F800000, 1, 0);
      send(1, 10'd0,   ONE,    0, 3'd0, 32'h80000000, 0, 1);
      send(1, 10'd127, ONE,    1, 3'd0, 32'h80000000, 0, 0);
      send(0, 10'd127, ONE,    2, 3'd0, 32'h7F800000, 0, 0);
      send(1, 10'd127, ONE,    3, 3'd0, 32'h7FC00000, 0, 0);
      send(0, 10'd127, ONE_ST, 0, 3'd3, 32'h3F800001, 0, 0);
      send(1, 10'd127, ONE_ST, 0, 3'd2, 32'hBF800001, 0, 0);
      send(0, 10'd127, ONE_ST, 0, 3'd2, 32'h3F800000, 0, 0);
      send(0, 10'd127, ONE_HF, 0, 3'd0, 32'h3F800000, 0, 0);
      send(0, 10'd127, ONE_HF, 0, 3'd4, 32'h3F800001, 0, 0);
      send(0, 10'd127, ONE_HF, 0, 3'd7, 32'h3F800000, 0, 0);
      send(0, 10'h3FF, ONE,    0, 3'd0, 32'h00000000, 0, 1);
      drain();

      bus.out_ready = 1'b0;
      n_acc = 0;
      fork
         begin
            send(0, 10'd127, ONE, 0, 3'd0, 32'h3F800000, 0, 0);
            send(0, 10'd128, ONE, 0, 3'd0, 32'h40000000, 0, 0);
            send(0, 10'd129, ONE, 0, 3'd0, 32'h40800000, 0, 0);
            send(0, 10'd130, ONE, 0, 3'd0, 32'h41000000, 0, 0);
            bp_done = 1;
         end
      join_none
      repeat (4) @(posedge clk);
      #2;
      chk("bp_accepted", 32'(n_acc), 32'd2);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      @(posedge clk);
      #2;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 100 && !bp_done; i++) begin
         @(posedge clk);
         #1;
      end
      chk("bp_done", 32'(bp_done), 32'd1);
      drain();
      chk("bp_count", 32'(n_acc), 32'd4);

      bus.out_ready = 1'b0;
      send(0, 10'd127, ONE, 0, 3'd0, 32'h3F800000, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("mid_out_valid", 32'(bus.out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_mid_fp_Z", bus.fp_Z, 32'd0);
      sb.delete();
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("post_rst_idle", 32'(bus.out_valid), 32'd0);

      send(1, 10'd128, ONE5SQ, 0, 3'd0, 32'hC0900000, 0, 0);
      drain();

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/fp_mul_round.md
Name: fp_mul_round

Overview:
- Downstream stage of the single-precision multiplier datapath.
- Consumes the raw 48-bit significand product, the pre-normalization exponent, the sign and a special-case class from the mantissa multiplier.
- Normalizes and rounds per r_mode, then packs IEEE-754 fp_Z with ovrf/udrf flags.
- Two-stage valid/ready pipeline; subnormals are flushed to zero (FTZ), matching the multiplier contract.

Parameters:
EXP_W, 10, signed width of incoming exponent sum
FRC_W, 48, width of significand product (1.m x 1.m)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream holds a product
in_ready  out  1  stage 1 can accept
in_sign  in  1  sign X xor sign Y
in_exp  in  EXP_W  two's-complement eX+eY-127 (biased, before normalization)
in_frc  in  FRC_W  significand product, bit 46 = units when no carry
in_cls  in  2  0 normal, 1 zero (includes subnormal operand), 2 inf, 3 nan
r_mode  in  3  captured with in_valid: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM, others treated as RNE
out_valid  out  1  result available
out_ready  in  1  downstream accepts
fp_Z  out  32  packed result
ovrf  out  1  overflow flag, qualified by out_valid
udrf  out  1  underflow (flush) flag, qualified by out_valid

Behaviour:
- Reset (async, rst_n=0): both stage valid bits 0; out_valid=0, fp_Z=0, ovrf=0, udrf=0. Reset mid-operation discards in-flight results; no output after release until new input.
- Handshake:
  - Transfer on valid&&ready.
  - Stage advances when its successor is empty or being drained this cycle.
  - in_ready = !s1_valid || s1_adv.
  - Latency 2 cycles with no stalls; throughput 1/cycle.
  - While out_valid && !out_ready, fp_Z/ovrf/udrf held stable.
  - Strict in-order delivery; no drops or duplicates.
- Stage 1 (normalize):
  - If in_frc[47]: mant = in_frc[46:24], guard = in_frc[23], sticky = |in_frc[22:0], exp_n = in_exp+1.
  - Else: mant = in_frc[45:23], guard = in_frc[22], sticky = |in_frc[21:0], exp_n = in_exp.
  - Register sign, cls, r_mode, exp_n, mant, guard, sticky.
- Stage 2 (round/pack), evaluated in priority order:
  - cls nan: fp_Z=7FC00000, flags 0.
  - cls inf: {sign, FF, 0}, flags 0.
  - cls zero: {sign, 31'b0}, flags 0.
  - exp_n <= 0: {sign, 31'b0}, udrf=1 (no subnormal output; rounding not applied).
  - Otherwise compute inc:
    - RNE: guard && (sticky || mant[0])
    - RTZ: 0
    - RDN: sign && (guard||sticky)
    - RUP: !sign && (guard||sticky)
    - RMM: guard
  - Apply rounding: mant_r = mant+inc. On carry out of 23 bits, mant_r = 0 and exp_n+1.
  - exp_final >= 255 sets ovrf=1, result by mode:
    - RNE/RMM: +-inf.
    - RTZ: +-7F7FFFFF.
    - RDN: +max if sign=0, -inf if sign=1.
    - RUP: +inf if sign=0, -max if sign=1.
  - Else fp_Z = {sign, exp_final[7:0], mant_r}.
- ovrf and udrf are never both 1.

Decomposition:
- Package fp_mul_pkg:
  - cls_e enum (CLS_NORM/ZERO/INF/NAN).
  - rmode_e enum (RNE, RTZ, RDN, RUP, RMM).
  - Constants QNAN=32'h7FC00000, MAX_FIN=31'h7F7FFFFF, EXP_MAX=255.
  - s1_t stage-register struct.
- One sub-module, fp_round_inc: combinational increment decision (sign, guard, sticky, lsb, r_mode -> inc). Reused by other FPU ops.

Test Plan:
- 1.0x1.0: in_exp=127, in_frc=1<<46, cls=0, RNE -> fp_Z=3F800000 two cycles later, flags 0.
- 1.5x1.5: in_exp=127, in_frc=9<<44 -> fp_Z=40100000.
- Rounding carry: in_exp=127, in_frc[45:22] all ones, rest 0, RNE -> fp_Z=40000000. Same input with RTZ -> 3FFFFFFF.
- Overflow: in_exp=254, in_frc[47]=1, sign 0:
  - RNE -> 7F800000, ovrf=1.
  - RTZ -> 7F7FFFFF, ovrf=1.
  - RDN with sign 1 -> FF800000.
- Underflow/specials:
  - in_exp=0, frc=1<<46, sign 1 -> 80000000, udrf=1.
  - cls zero -> signed zero.
  - cls nan -> 7FC00000.
- Backpressure/reset:
  - Stream 4 inputs with out_ready=0 for 3 cycles: in_ready drops after 2 accepted, outputs held stable, all 4 results emerge in order.
  - Assert rst_n mid-stream: out_valid=0 immediately, no stale result after release.
